// File: rtl/elliot_pkg.sv
// Shared definitions for the inverse Elliot activation block: default
// word geometry, fixed-point constants and the controller state encoding.
package elliot_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int FRAC_W_DEF = 16;

  // 1.0 in Q16.16 and the symmetric saturation codes for the default width.
  localparam logic [DATA_W_DEF-1:0] ONE_DEF     = 32'h0001_0000;
  localparam logic [DATA_W_DEF-1:0] SAT_POS_DEF = 32'h7FFF_FFFF;
  localparam logic [DATA_W_DEF-1:0] SAT_NEG_DEF = 32'h8000_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/elliot_inverse_if.sv
// Request/result bundle of the inverse Elliot block.
// Optional macro ELLIOT_INV_SAT_FLAG_EN adds the sat flag.
//
// Handshake: the requester raises start for one or more cycles with y_in
// valid alongside; the block takes y_in only on the edge where it is idle
// and start is high, then raises busy. Starts seen while busy (including the
// final DONE cycle) are dropped, never queued. The result appears on x_out
// together with a single-cycle end_signal pulse, in the same cycle busy
// falls; x_out (and sat) then hold until the next result is written.
interface elliot_inverse_if #(
  parameter int DATA_W = 32
) ();
  logic              start;
  logic [DATA_W-1:0] y_in;
  logic [DATA_W-1:0] x_out;
  logic              end_signal;
  logic              busy;
`ifdef ELLIOT_INV_SAT_FLAG_EN
  logic              sat;

  modport master (output start, y_in, input x_out, end_signal, busy, sat);
  modport slave  (input start, y_in, output x_out, end_signal, busy, sat);
`else
  modport master (output start, y_in, input x_out, end_signal, busy);
  modport slave  (input start, y_in, output x_out, end_signal, busy);
`endif
endinterface

// File: rtl/elliot_inv_divider.sv
// Serial unsigned restoring divider, one quotient bit per clock, MSB first.
// The remainder never reaches den, and den is at most 1<<FRAC_W, so a
// FRAC_W+1 bit remainder register is enough for the shifted trial value.
module elliot_inv_divider #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] num,
  input  logic [FRAC_W:0]   den,
  output logic [DATA_W-1:0] q,
  output logic              done
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [FRAC_W:0]   rem_q, rem_d;
  logic [FRAC_W:0]   den_q, den_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic [FRAC_W+1:0] trial;
  logic [FRAC_W:0]   diff;

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  always_comb begin
    n_d   = n_q;
    q_d   = q_q;
    rem_d = rem_q;
    den_d = den_q;
    cnt_d = cnt_q;
    run_d = run_q;
    trial = {rem_q, n_q[DATA_W-1]};
    diff  = trial[FRAC_W:0] - den_q;
    if (load) begin
      n_d   = num;
      q_d   = '0;
      rem_d = '0;
      den_d = den;
      cnt_d = CNT_W'(DATA_W - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      n_d = {n_q[DATA_W-2:0], 1'b0};
      if (trial >= {1'b0, den_q}) begin
        rem_d = diff;
        q_d   = {q_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = trial[FRAC_W:0];
        q_d   = {q_q[DATA_W-2:0], 1'b0};
      end
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q   <= '0;
      q_q   <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      n_q   <= n_d;
      q_q   <= q_d;
      rem_q <= rem_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign q    = q_q;
  assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/elliot_inverse.sv
// Inverse Elliot activation: x = y / (1 - |y|) in signed fixed point.
// Controller (IDLE/PREP/DIV/DONE), sign/magnitude handling and symmetric
// saturation live here; the division runs in elliot_inv_divider.
// Optional macro ELLIOT_INV_SAT_FLAG_EN reports saturation on bus.sat.
module elliot_inverse
  import elliot_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  elliot_inverse_if.slave     bus,
  output state_e              dbg_state
);
  localparam logic [DATA_W:0]   ONE     = {{(DATA_W-FRAC_W){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              sgn_q, sgn_d;
  logic              dom_err_q, dom_err_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              end_q, end_d;
  logic              busy_q, busy_d;
`ifdef ELLIOT_INV_SAT_FLAG_EN
  logic              sat_q, sat_d;
`endif

  logic [DATA_W:0]   y_ext, a;
  logic              dom_err;
  logic [FRAC_W:0]   den;
  logic [DATA_W-1:0] num, q;
  logic              div_load, div_done, ovf;

  // Magnitude is formed one bit wider so the most-negative code has a valid
  // |y| (which is then a domain error). Out of domain, den is forced to 1 so
  // the divider still terminates; its quotient is discarded by saturation.
  always_comb begin
    y_ext   = {y_q[DATA_W-1], y_q};
    a       = y_q[DATA_W-1] ? -y_ext : y_ext;
    dom_err = (a >= ONE);
    den     = dom_err ? {{FRAC_W{1'b0}}, 1'b1} : (ONE[FRAC_W:0] - a[FRAC_W:0]);
    num     = {a[DATA_W-FRAC_W-1:0], {FRAC_W{1'b0}}};
    ovf     = dom_err_q | q[DATA_W-1];
  end

  assign div_load = (state_q == PREP);

  elliot_inv_divider #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (div_load),
    .num   (num),
    .den   (den),
    .q     (q),
    .done  (div_done)
  );

  // Controller next state and registered outputs.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    sgn_d     = sgn_q;
    dom_err_d = dom_err_q;
    x_d       = x_q;
    end_d     = 1'b0;
    busy_d    = busy_q;
`ifdef ELLIOT_INV_SAT_FLAG_EN
    sat_d     = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          y_d     = bus.y_in;
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        sgn_d     = y_q[DATA_W-1];
        dom_err_d = dom_err;
        state_d   = DIV;
      end
      DIV: begin
        if (div_done) state_d = DONE;
      end
      DONE: begin
        if (ovf) x_d = sgn_q ? SAT_NEG : SAT_POS;
        else     x_d = sgn_q ? -q : q;
`ifdef ELLIOT_INV_SAT_FLAG_EN
        sat_d   = ovf;
`endif
        end_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; reset aborts any conversion without a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= '0;
      sgn_q     <= 1'b0;
      dom_err_q <= 1'b0;
      x_q       <= '0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ELLIOT_INV_SAT_FLAG_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      sgn_q     <= sgn_d;
      dom_err_q <= dom_err_d;
      x_q       <= x_d;
      end_q     <= end_d;
      busy_q    <= busy_d;
`ifdef ELLIOT_INV_SAT_FLAG_EN
      sat_q     <= sat_d;
`endif
    end
  end

  assign bus.x_out      = x_q;
  assign bus.end_signal = end_q;
  assign bus.busy       = busy_q;
`ifdef ELLIOT_INV_SAT_FLAG_EN
  assign bus.sat        = sat_q;
`endif
  assign dbg_state      = state_q;

endmodule
